// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared types and widths for the phase increment calculator (PHASE_DELTA_ROUND_EN)
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } phase_calc_state_t;

  localparam int PHASE_W = 32;

`ifdef PHASE_DELTA_ROUND_EN
  // One extra quotient bit below the LSB carries the half-LSB for rounding.
  localparam int DIV_ITERS = PHASE_W + 1;
`else
  localparam int DIV_ITERS = PHASE_W;
`endif

  localparam int ITER_W = $clog2(DIV_ITERS + 1);

endpackage

// File: rtl/serial_divider.sv
// rtl/serial_divider.sv - bit-serial restoring divider by a constant, one quotient bit per cycle
module serial_divider
  import apu_pkg::*;
#(
  parameter int unsigned DIVISOR = 25_000_000,
  parameter int          NUM_W   = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [NUM_W-1:0]     i_num,
  output logic                 o_done,
  output logic [DIV_ITERS-1:0] o_quotient_next
);

  localparam int REM_W = $clog2(DIVISOR) + 1;
  localparam logic [REM_W:0]    DIV_EXT = (REM_W + 1)'(DIVISOR);
  localparam logic [ITER_W-1:0] LAST    = ITER_W'(DIV_ITERS - 1);

  logic [REM_W-1:0]     rem_q, rem_d;
  logic [DIV_ITERS-1:0] quo_q, quo_d;
  logic [ITER_W-1:0]    cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [REM_W:0]       rem2;

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    o_done = 1'b0;
    rem2   = {rem_q, 1'b0};
    if (busy_q) begin
      // rem < DIVISOR always, so rem2 < 2*DIVISOR fits back in REM_W bits.
      if (rem2 >= DIV_EXT) begin
        rem_d = REM_W'(rem2 - DIV_EXT);
        quo_d = {quo_q[DIV_ITERS-2:0], 1'b1};
      end else begin
        rem_d = REM_W'(rem2);
        quo_d = {quo_q[DIV_ITERS-2:0], 1'b0};
      end
      cnt_d = cnt_q + ITER_W'(1);
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        o_done = 1'b1;
      end
    end else if (i_start) begin
      rem_d  = REM_W'(i_num);
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end
    o_quotient_next = quo_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/phase_delta_calc.sv
// rtl/phase_delta_calc.sv - frequency to phase increment converter; PHASE_DELTA_ROUND_EN selects round-half-up
module phase_delta_calc
  import apu_pkg::*;
#(
  parameter int unsigned SAMPLE_HZ = 25_000_000,
  parameter int          FREQ_W    = 24
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [FREQ_W-1:0]  i_freq_hz,
  input  logic               i_freq_valid,
  output logic               o_freq_ready,
  output logic [PHASE_W-1:0] o_phase_delta,
  output logic               o_phase_delta_valid,
  output logic               o_error
);

  phase_calc_state_t    state_q, state_d;
  logic                 ready_q, ready_d;
  logic [PHASE_W-1:0]   delta_q, delta_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 div_start;
  logic                 div_done;
  logic [DIV_ITERS-1:0] quo_next;
  logic [PHASE_W-1:0]   result;
  logic                 out_of_range;

  serial_divider #(
    .DIVISOR (SAMPLE_HZ),
    .NUM_W   (FREQ_W)
  ) u_div (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (div_start),
    .i_num           (i_freq_hz),
    .o_done          (div_done),
    .o_quotient_next (quo_next)
  );

  assign out_of_range = 64'(i_freq_hz) >= 64'(SAMPLE_HZ);

`ifdef PHASE_DELTA_ROUND_EN
  logic [PHASE_W:0] rounded;
  always_comb begin
    rounded = {1'b0, quo_next[PHASE_W:1]} + (PHASE_W + 1)'(quo_next[0]);
    result  = rounded[PHASE_W] ? '1 : rounded[PHASE_W-1:0];
  end
`else
  assign result = quo_next;
`endif

  // The result register is loaded on the edge that completes the last step,
  // so the registered output is already valid during the DONE cycle.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    delta_d   = delta_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (i_freq_valid && ready_q) begin
          ready_d = 1'b0;
          if (out_of_range) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            div_start = 1'b1;
            state_d   = DIV;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          delta_d = result;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      delta_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign o_freq_ready        = ready_q;
  assign o_phase_delta       = delta_q;
  assign o_phase_delta_valid = valid_q;
  assign o_error             = error_q;

endmodule

// File: doc/phase_delta_calc.md
# phase_delta_calc

Converts a frequency in Hz into the 32-bit phase increment consumed by `phase_generator`: `delta = floor(freq · 2^32 / SAMPLE_HZ)`. It uses a bit-serial restoring divider, so it needs no hardware multiplier or divider. It sits on the write side of the `phase_generator` delta interface; its `o_phase_delta` / `o_phase_delta_valid` pair connects directly to `i_phase_delta` / `i_phase_delta_valid`. The request source (register file or sequencer) hands off frequencies through a valid/ready handshake.

## Interface
- `SAMPLE_HZ`, default 25_000_000: phase-accumulator update rate in Hz (the divisor).
- `FREQ_W`, default 24: width of the frequency input.
- `i_clk` in 1: sole clock, rising edge.
- `i_rst_n` in 1: reset, synchronous and active-low.
- `i_freq_hz` in FREQ_W: requested frequency in Hz, unsigned.
- `i_freq_valid` in 1: request present.
- `o_freq_ready` out 1: block can accept a request.
- `o_phase_delta` out 32: last computed phase increment. Holds its value between results.
- `o_phase_delta_valid` out 1: one-cycle pulse when `o_phase_delta` has just been updated.
- `o_error` out 1: one-cycle pulse when a request was rejected as out of range.

## Operation
- States: IDLE, DIV, DONE. Reset state is IDLE.
- Reset values: `o_freq_ready`=1, `o_phase_delta`=0, `o_phase_delta_valid`=0, `o_error`=0.
- IDLE:
  - `o_freq_ready`=1.
  - When `i_freq_valid && o_freq_ready`, latch `i_freq_hz`.
  - If `i_freq_hz >= SAMPLE_HZ`: set an error flag and go to DONE. No division is performed.
  - Otherwise: remainder ← freq, iteration count ← 0, go to DIV.
- DIV, one quotient bit per cycle:
  - `rem2 = rem << 1`.
  - If `rem2 >= SAMPLE_HZ`: rem ← `rem2 − SAMPLE_HZ`, shift 1 into the quotient. Else: rem ← `rem2`, shift 0 into the quotient.
  - After 32 iterations, go to DONE.
- DONE:
  - Error case: pulse `o_error`; `o_phase_delta` is unchanged.
  - Otherwise: load `o_phase_delta` ← quotient and pulse `o_phase_delta_valid`.
  - Return to IDLE.
- Width rules:
  - Remainder width is `$clog2(SAMPLE_HZ)+1`; this holds `rem2 < 2·SAMPLE_HZ`.
  - Quotient is 32 bits. The range check guarantees the true quotient is below 2^32.
- `i_freq_hz`=0 is legal: result 0, valid pulsed.
- `i_freq_valid` while busy: ignored (`o_freq_ready`=0). The requester holds the request.
- Deassertion of `i_freq_valid` during DIV has no effect. The input is latched at acceptance.
- Reset asserted mid-division: the operation is aborted, no valid or error pulse is produced, and all outputs take their reset values on the next edge.

## Timing
- Acceptance edge is cycle 0.
- DIV occupies cycles 1–32.
- DONE is cycle 33: `o_phase_delta` updates and `o_phase_delta_valid` is high during cycle 33.
- `o_freq_ready` is low in cycles 1–33 and high again in cycle 34. Throughput is one result per 34 cycles.
- Error path: `o_error` is high in cycle 1, and ready returns in cycle 2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `PHASE_DELTA_ROUND_EN` defined:
  - DIV runs 33 iterations; the extra bit is the half-LSB.
  - DONE loads `quotient[32:1] + quotient[0]` (round half up), saturating at 0xFFFFFFFF.
  - Every latency above grows by one cycle: valid in cycle 34, ready in cycle 35.
- Not defined: truncation with 32 iterations, as described above.

## Structure
- Shared package `apu_pkg`:
  - state enum `phase_calc_state_t` (IDLE, DIV, DONE);
  - localparam `PHASE_W`=32;
  - iteration-count width.
- Natural sub-module: `serial_divider`, which holds the remainder/quotient registers and the step logic, with start/done ports. `phase_delta_calc` keeps the FSM, the range check and the output registers.

## Test plan
All scenarios use SAMPLE_HZ=25_000_000.
- Freq 440 → `o_phase_delta`=75591 (0x00012747), valid exactly at cycle 33. With ROUND_EN: 75591 at cycle 34.
- Freq 1 → 171. With ROUND_EN: 172.
- Freq 12_500_000 → 0x80000000. Freq 24_999_999 → 0xFFFFFF54. Freq 0 → 0 with valid pulsed.
- Freq 25_000_000 → `o_error` pulse in cycle 1, no valid, `o_phase_delta` keeps its prior value, ready back in cycle 2.
- Back-to-back requests with valid held high → second request accepted at cycle 34. Changing `i_freq_hz` mid-division does not alter the first result.
- `i_rst_n` low at cycle 10 of a division → no valid, outputs 0 and ready 1 after the reset edge, then a fresh 440 request yields 75591.
